dma_xfer_engine: RTL and testbench
==================================

// Module: dma_xfer_engine
// PURPOSE
//  Datapath/sequencer stage directly downstream of the DMA register block.
//  Consumes the start pulse and transfer config (word count, direction, IO/MEM addresses).
//  Moves 32-bit words one at a time over a req/ack master bus: read source, then write destination.
//  Returns busy/state/count/error information for the STATUS, TRANSFER_COUNT and ERROR_STATUS regs.
// PARAMETERS
//  TIMEOUT_CYC  255  max cycles bus_req may wait for bus_ack before a timeout error (>=1)
//  MEM_STRIDE   4    byte increment of the memory-side address after each word
//  IO_STRIDE    0    byte increment of the IO-side address after each word (0 = fixed FIFO port)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   asynchronous reset, active-low
//  start      in   1   one-cycle start pulse (from CTRL.start_dma)
//  w_count    in   15  number of words to move; sampled on start
//  io_mem     in   1   1 = IO->MEM, 0 = MEM->IO; sampled on start
//  io_addr    in   32  IO-side byte address; sampled on start
//  mem_addr   in   32  memory-side byte address; sampled on start
//  abort      in   1   stop request, honoured at the next word boundary
//  bus_req    out  1   bus request; held until bus_ack
//  bus_we     out  1   1 = write, 0 = read; stable while bus_req
//  bus_addr   out  32  byte address; stable while bus_req
//  bus_wdata  out  32  write data; stable while bus_req && bus_we
//  bus_ack    in   1   one-cycle completion of the current request
//  bus_rdata  in   32  read data; valid with bus_ack on a read
//  bus_err    in   1   error response; valid only with bus_ack
//  busy       out  1   high in RD/WR states
//  state      out  4   0 IDLE, 1 RD, 2 WR, 3 DONE, 4 ERR
//  done       out  1   one-cycle pulse: transfer completed or aborted
//  aborted    out  1   one-cycle pulse, coincident with done, when ended by abort
//  err_bus    out  1   one-cycle pulse: bus_err received
//  err_timeout out 1   one-cycle pulse: ack timeout
//  err_align  out  1   one-cycle pulse: io_addr[1:0] or mem_addr[1:0] nonzero at start
//  xfer_count out  32  words fully written since last accepted start
//  err_offset out  16  xfer_count[15:0] captured when an error is flagged
// BEHAVIOUR
//  All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
//  Reset mid-transfer drops bus_req immediately; no resume after reset.
//  IDLE: start is accepted only here; start seen in any other state is ignored.
//   - start && abort in the same cycle: abort wins, start is ignored.
//   - On accepted start: latch the config and clear xfer_count to 0.
//     - Misaligned address: next state ERR with err_align.
//     - Else w_count==0: next state DONE with no bus traffic.
//     - Else: next state RD.
//   - Source/destination: io_mem=1 reads io_addr, writes mem_addr; io_mem=0 is the reverse.
//  RD: bus_req=1, bus_we=0, bus_addr=src, asserted in the first cycle of RD.
//   - bus_ack && !bus_err: capture bus_rdata into the hold reg; next state WR.
//   - bus_ack && bus_err: next state ERR with err_bus.
//  WR: bus_req=1, bus_we=1, bus_addr=dst, bus_wdata=hold reg.
//   - bus_ack && bus_err: next state ERR with err_bus; xfer_count does not increment.
//   - bus_ack && !bus_err: xfer_count+=1; advance src/dst by their strides (32-bit wrap).
//     Next state, first matching rule: new count==w_count -> DONE; abort latched -> DONE
//     with aborted; else RD.
//   - Back-to-back: after a WR ack the next RD request starts the following cycle.
//  Abort: a pulse seen in RD/WR is latched and acted on only at a WR ack.
//   - A request is never dropped before its ack; the latch clears on entering IDLE.
//  Timeout: counter clears on each new request and on ack, increments each cycle of
//   req && !ack. Reaching TIMEOUT_CYC: drop bus_req, next state ERR with err_timeout.
//   An ack arriving in that same cycle wins and is processed normally.
//  DONE: done=1 for exactly one cycle, then IDLE. ERR: the matching err_* pulse=1 for one
//   cycle and err_offset=xfer_count[15:0] (held until next error), then IDLE.
//   done is not asserted on error. xfer_count holds its value in IDLE.
//  bus_req is never high in IDLE/DONE/ERR; at most one outstanding request.
// TESTING
//  IO->MEM, w_count=3, io=0x100, mem=0x2000, ack 1 cycle -> reads 0x100 x3, writes 0x2000/4/8, done, count=3
//  w_count=0 -> no bus_req, done pulse 2 cycles after start, xfer_count=0
//  mem_addr=0x2002 -> err_align pulse, no bus_req, err_offset=0
//  bus_err on the 2nd write of 4 -> err_bus pulse, xfer_count=1, err_offset=1, bus idle after
//  ack withheld, TIMEOUT_CYC=8 -> req high 8 cycles, err_timeout pulse; abort mid-word 2 of 5 -> done+aborted, count=2
//  start pulse while busy -> ignored; rst_n low mid-WR -> bus_req=0, state=0 at once

Source files
------------

// File: rtl/dma_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_xfer_engine
// Description : Word-at-a-time DMA sequencer that sits behind the DMA register
//               block. On an accepted start it copies w_count 32-bit words
//               over a single-outstanding req/ack master bus. Each word is a
//               read of the source followed by a write of the destination.
//               It reports busy/state/count and pulses done, aborted and
//               error flags.
// Ports       : clk, rst_n (async, active-low)
//               start/w_count/io_mem/io_addr/mem_addr - transfer config,
//                                                       sampled on start
//               abort         - stop at the next completed word
//               bus_req/we/addr/wdata, bus_ack/rdata/err - master bus
//               busy/state/xfer_count/err_offset      - status
//               done/aborted/err_bus/err_timeout/err_align - one-cycle pulses
// Revision    : 1.0 - initial release
// ============================================================================
module dma_xfer_engine #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] MEM_STRIDE  = 32'd4,
  parameter logic [31:0] IO_STRIDE   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] w_count,
  input  logic        io_mem,
  input  logic [31:0] io_addr,
  input  logic [31:0] mem_addr,
  input  logic        abort,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        busy,
  output logic [3:0]  state,
  output logic        done,
  output logic        aborted,
  output logic        err_bus,
  output logic        err_timeout,
  output logic        err_align,
  output logic [31:0] xfer_count,
  output logic [15:0] err_offset
);

  // The wait counter only ever holds 0..TIMEOUT_CYC-1.
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RD   = 4'd1,
    S_WR   = 4'd2,
    S_DONE = 4'd3,
    S_ERR  = 4'd4
  } state_e;

  localparam logic [1:0] E_BUS   = 2'd0;
  localparam logic [1:0] E_TMO   = 2'd1;
  localparam logic [1:0] E_ALIGN = 2'd2;

  state_e            state_q, state_d;
  logic [31:0]       xfer_q, xfer_d;
  logic [14:0]       wcnt_q, wcnt_d;
  logic              dir_q, dir_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [31:0]       hold_q, hold_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              abort_lat_q, abort_lat_d;
  logic              end_abort_q, end_abort_d;
  logic [1:0]        err_kind_q, err_kind_d;

  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              err_bus_q, err_bus_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_align_q, err_align_d;
  logic [15:0]       err_offset_q, err_offset_d;

  logic [31:0]       xfer_inc;
  logic [31:0]       src_stride;
  logic [31:0]       dst_stride;

  assign xfer_inc   = xfer_q + 32'd1;
  // io_mem=1 reads the IO side and writes memory; io_mem=0 is the reverse.
  assign src_stride = dir_q ? IO_STRIDE  : MEM_STRIDE;
  assign dst_stride = dir_q ? MEM_STRIDE : IO_STRIDE;

  always_comb begin
    state_d     = state_q;
    xfer_d      = xfer_q;
    wcnt_d      = wcnt_q;
    dir_d       = dir_q;
    src_d       = src_q;
    dst_d       = dst_q;
    hold_d      = hold_q;
    tmo_d       = '0;
    abort_lat_d = abort_lat_q;
    end_abort_d = end_abort_q;
    err_kind_d  = err_kind_q;

    case (state_q)
      S_IDLE: begin
        abort_lat_d = 1'b0;
        // A simultaneous abort cancels the start.
        if (start && !abort) begin
          wcnt_d      = w_count;
          dir_d       = io_mem;
          src_d       = io_mem ? io_addr  : mem_addr;
          dst_d       = io_mem ? mem_addr : io_addr;
          xfer_d      = 32'd0;
          end_abort_d = 1'b0;
          if ((io_addr[1:0] != 2'b00) || (mem_addr[1:0] != 2'b00)) begin
            state_d    = S_ERR;
            err_kind_d = E_ALIGN;
          end else if (w_count == 15'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD, S_WR: begin
        // Abort only takes effect at a write ack, so the word in flight
        // always completes.
        abort_lat_d = abort_lat_q | abort;
        if (bus_ack) begin
          if (bus_err) begin
            state_d    = S_ERR;
            err_kind_d = E_BUS;
          end else if (state_q == S_RD) begin
            hold_d  = bus_rdata;
            state_d = S_WR;
          end else begin
            xfer_d = xfer_inc;
            src_d  = src_q + src_stride;
            dst_d  = dst_q + dst_stride;
            if (xfer_inc == {17'd0, wcnt_q}) begin
              state_d = S_DONE;
            end else if (abort_lat_q || abort) begin
              state_d     = S_DONE;
              end_abort_d = 1'b1;
            end else begin
              state_d = S_RD;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_ERR;
          err_kind_d = E_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_DONE, S_ERR: begin
        abort_lat_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Bus outputs follow the state being entered so the request is visible in
    // the first cycle of RD/WR and drops as soon as the FSM leaves them.
    bus_req_d   = (state_d == S_RD) || (state_d == S_WR);
    busy_d      = bus_req_d;
    bus_we_d    = (state_d == S_WR);
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if (state_d == S_RD) begin
      bus_addr_d = src_d;
    end else if (state_d == S_WR) begin
      bus_addr_d  = dst_d;
      bus_wdata_d = hold_d;
    end

    // Completion pulses are emitted on the way out of DONE/ERR.
    done_d        = (state_q == S_DONE);
    aborted_d     = (state_q == S_DONE) && end_abort_q;
    err_bus_d     = (state_q == S_ERR) && (err_kind_q == E_BUS);
    err_timeout_d = (state_q == S_ERR) && (err_kind_q == E_TMO);
    err_align_d   = (state_q == S_ERR) && (err_kind_q == E_ALIGN);
    err_offset_d  = (state_q == S_ERR) ? xfer_q[15:0] : err_offset_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      xfer_q        <= '0;
      wcnt_q        <= '0;
      dir_q         <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      hold_q        <= '0;
      tmo_q         <= '0;
      abort_lat_q   <= 1'b0;
      end_abort_q   <= 1'b0;
      err_kind_q    <= E_BUS;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_bus_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_align_q   <= 1'b0;
      err_offset_q  <= '0;
    end else begin
      state_q       <= state_d;
      xfer_q        <= xfer_d;
      wcnt_q        <= wcnt_d;
      dir_q         <= dir_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
      abort_lat_q   <= abort_lat_d;
      end_abort_q   <= end_abort_d;
      err_kind_q    <= err_kind_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      err_bus_q     <= err_bus_d;
      err_timeout_q <= err_timeout_d;
      err_align_q   <= err_align_d;
      err_offset_q  <= err_offset_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign busy        = busy_q;
  assign state       = state_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign err_bus     = err_bus_q;
  assign err_timeout = err_timeout_q;
  assign err_align   = err_align_q;
  assign xfer_count  = xfer_q;
  assign err_offset  = err_offset_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_xfer_engine
// Description : Self-checking bench for dma_xfer_engine. A transaction-level
//               reference model predicts every output each cycle. A random
//               bus slave and random start/abort traffic drive the DUT.
//               Directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_xfer_engine;

  localparam int          TMO    = 8;
  localparam logic [31:0] MEM_ST = 32'd4;
  localparam logic [31:0] IO_ST  = 32'd0;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] w_count;
  logic        io_mem;
  logic [31:0] io_addr;
  logic [31:0] mem_addr;
  logic        abort;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        busy;
  logic [3:0]  state;
  logic        done;
  logic        aborted;
  logic        err_bus;
  logic        err_timeout;
  logic        err_align;
  logic [31:0] xfer_count;
  logic [15:0] err_offset;

  dma_xfer_engine #(
    .TIMEOUT_CYC (TMO),
    .MEM_STRIDE  (MEM_ST),
    .IO_STRIDE   (IO_ST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .w_count     (w_count),
    .io_mem      (io_mem),
    .io_addr     (io_addr),
    .mem_addr    (mem_addr),
    .abort       (abort),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err),
    .busy        (busy),
    .state       (state),
    .done        (done),
    .aborted     (aborted),
    .err_bus     (err_bus),
    .err_timeout (err_timeout),
    .err_align   (err_align),
    .xfer_count  (xfer_count),
    .err_offset  (err_offset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. A transfer of N words is the op list
  //   op k: word k/2; even k = read src+word*src_stride,
  //         odd k = write dst+word*dst_stride.
  // The model walks that list on acks. Once an ending is decided there is one
  // terminal cycle (DONE/ERR), then one cycle carrying the result pulse.
  // --------------------------------------------------------------------------
  bit          m_act, m_pend, m_abt;
  int          m_kind;            // 0 done, 1 aborted, 2 bus err, 3 timeout, 4 align
  int unsigned m_k, m_n, m_wait, m_cnt;
  logic [31:0] m_src, m_dst, m_ss, m_ds, m_hold;
  logic [15:0] m_off;
  bit          e_done, e_abt, e_eb, e_et, e_ea;

  function automatic logic [31:0] op_addr(input int unsigned k);
    logic [31:0] w;
    w = k / 2;
    return (k % 2 == 1) ? (m_dst + w * m_ds) : (m_src + w * m_ss);
  endfunction

  function automatic logic [3:0] exp_state();
    if (m_pend) return (m_kind < 2) ? 4'd3 : 4'd4;
    if (m_act)  return (m_k % 2 == 1) ? 4'd2 : 4'd1;
    return 4'd0;
  endfunction

  task automatic m_end(input int kind);
    m_act  = 1'b0;
    m_pend = 1'b1;
    m_kind = kind;
  endtask

  task automatic m_reset();
    m_act = 0; m_pend = 0; m_abt = 0; m_kind = 0;
    m_k = 0; m_n = 0; m_wait = 0; m_cnt = 0;
    m_src = 0; m_dst = 0; m_ss = 0; m_ds = 0; m_hold = 0; m_off = 0;
    e_done = 0; e_abt = 0; e_eb = 0; e_et = 0; e_ea = 0;
  endtask

  task automatic m_step();
    e_done = 0; e_abt = 0; e_eb = 0; e_et = 0; e_ea = 0;
    if (m_pend) begin
      case (m_kind)
        0: e_done = 1;
        1: begin e_done = 1; e_abt = 1; end
        2: e_eb = 1;
        3: e_et = 1;
        default: e_ea = 1;
      endcase
      if (m_kind >= 2) m_off = m_cnt[15:0];
      m_pend = 0;
    end else if (m_act) begin
      if (abort) m_abt = 1;
      if (bus_ack) begin
        m_wait = 0;
        if (bus_err) begin
          m_end(2);
        end else if (m_k % 2 == 0) begin
          m_hold = bus_rdata;
          m_k++;
        end else begin
          m_cnt++;
          m_k++;
          if (m_cnt == m_n) m_end(0);
          else if (m_abt) m_end(1);
        end
      end else begin
        m_wait++;
        if (m_wait == TMO) m_end(3);
      end
    end else if (start && !abort) begin
      m_cnt = 0;
      m_n   = w_count;
      m_src = io_mem ? io_addr : mem_addr;
      m_dst = io_mem ? mem_addr : io_addr;
      m_ss  = io_mem ? IO_ST : MEM_ST;
      m_ds  = io_mem ? MEM_ST : IO_ST;
      if ((io_addr % 4 != 0) || (mem_addr % 4 != 0)) begin
        m_pend = 1; m_kind = 4;
      end else if (m_n == 0) begin
        m_pend = 1; m_kind = 0;
      end else begin
        m_act = 1; m_k = 0; m_wait = 0; m_abt = 0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy",        busy,        m_act);
        chk("bus_req",     bus_req,     m_act);
        chk("state",       state,       exp_state());
        chk("xfer_count",  xfer_count,  m_cnt);
        chk("err_offset",  err_offset,  m_off);
        chk("done",        done,        e_done);
        chk("aborted",     aborted,     e_abt);
        chk("err_bus",     err_bus,     e_eb);
        chk("err_timeout", err_timeout, e_et);
        chk("err_align",   err_align,   e_ea);
        if (m_act) begin
          chk("bus_we",   bus_we,   m_k % 2);
          chk("bus_addr", bus_addr, op_addr(m_k));
          if (m_k % 2 == 1) chk("bus_wdata", bus_wdata, m_hold);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus slave: random ack latency, optional forced error on a given ack index.
  // --------------------------------------------------------------------------
  int          ack_pct      = 100;
  int          err_pct      = 0;
  int          force_err_at = -1;
  int          ack_idx      = 0;
  logic [31:0] wr_log[$];
  logic [31:0] rd_log[$];

  initial begin
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = $urandom;
      if (rst_n && bus_req && ($urandom_range(0, 99) < ack_pct)) begin
        bus_ack = 1'b1;
        bus_err = (ack_idx == force_err_at) || ($urandom_range(0, 99) < err_pct);
        if (bus_we) wr_log.push_back(bus_addr);
        else        rd_log.push_back(bus_addr);
        ack_idx++;
      end
    end
  end

  // Event counters used by the directed checks.
  int n_done, n_abt, n_eb, n_et, n_ea, n_req;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_done += int'(done);
        n_abt  += int'(aborted);
        n_eb   += int'(err_bus);
        n_et   += int'(err_timeout);
        n_ea   += int'(err_align);
        n_req  += int'(bus_req);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic quiesce();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    n_done = 0; n_abt = 0; n_eb = 0; n_et = 0; n_ea = 0; n_req = 0;
    ack_idx = 0;
    wr_log.delete();
    rd_log.delete();
  endtask

  task automatic launch(input logic [14:0] n, input logic dir,
                        input logic [31:0] ia, input logic [31:0] ma);
    @(negedge clk);
    start = 1'b1; w_count = n; io_mem = dir; io_addr = ia; mem_addr = ma;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (!(state == 4'd0 && !bus_req) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, (cyc < 300) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_count = '0; io_mem = 1'b0;
    io_addr = '0; mem_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req",    bus_req,    0);
    chk("rst_state",      state,      0);
    chk("rst_busy",       busy,       0);
    chk("rst_xfer_count", xfer_count, 0);
    chk("rst_err_offset", err_offset, 0);
    chk("rst_done",       done,       0);
    rst_n = 1'b1;
    quiesce();

    // IO->MEM, 3 words, immediate ack.
    ack_pct = 100;
    launch(15'd3, 1'b1, 32'h100, 32'h2000);
    wait_idle("t1_idle");
    chk("t1_count", xfer_count, 3);
    chk("t1_done",  n_done, 1);
    chk("t1_nrd",   rd_log.size(), 3);
    chk("t1_nwr",   wr_log.size(), 3);
    if (wr_log.size() == 3 && rd_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_rd_addr", rd_log[i], 32'h100);
        chk("t1_wr_addr", wr_log[i], 32'h2000 + 4 * i);
      end
    end
    quiesce();

    // Zero-length transfer.
    launch(15'd0, 1'b0, 32'h40, 32'h1000);
    wait_idle("t2_idle");
    chk("t2_req_cycles", n_req, 0);
    chk("t2_done",       n_done, 1);
    chk("t2_count",      xfer_count, 0);
    quiesce();

    // Bus error on the 2nd write of 4 (ack index 3).
    force_err_at = 3;
    launch(15'd4, 1'b0, 32'h80, 32'h3000);
    wait_idle("t3_idle");
    force_err_at = -1;
    chk("t3_err_bus", n_eb, 1);
    chk("t3_done",    n_done, 0);
    chk("t3_count",   xfer_count, 1);
    chk("t3_offset",  err_offset, 1);
    chk("t3_req_low", bus_req, 0);
    quiesce();

    // Misaligned memory address.
    launch(15'd2, 1'b1, 32'h100, 32'h2002);
    wait_idle("t4_idle");
    chk("t4_err_align",  n_ea, 1);
    chk("t4_req_cycles", n_req, 0);
    chk("t4_offset",     err_offset, 0);
    quiesce();

    // Ack withheld -> timeout after TMO request cycles.
    ack_pct = 0;
    launch(15'd2, 1'b1, 32'h100, 32'h2000);
    wait_idle("t5_idle");
    chk("t5_req_cycles", n_req, TMO);
    chk("t5_err_tmo",    n_et, 1);
    chk("t5_done",       n_done, 0);
    ack_pct = 100;
    quiesce();

    // Abort during word 2 of 5.
    launch(15'd5, 1'b0, 32'h600, 32'h4000);
    cyc = 0;
    while (xfer_count != 32'd1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t6_idle");
    chk("t6_done",    n_done, 1);
    chk("t6_aborted", n_abt, 1);
    chk("t6_count",   xfer_count, 2);
    quiesce();

    // Start while busy is ignored; memory address wraps past 2^32.
    launch(15'd4, 1'b1, 32'h500, 32'hFFFF_FFF8);
    @(negedge clk);
    start = 1'b1; w_count = 15'd1; io_addr = 32'h40; mem_addr = 32'h80;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t7_idle");
    chk("t7_count", xfer_count, 4);
    chk("t7_done",  n_done, 1);
    chk("t7_nwr",   wr_log.size(), 4);
    if (wr_log.size() == 4) chk("t7_wrap_addr", wr_log[3], 32'h4);
    quiesce();

    // Reset in the middle of a write.
    launch(15'd3, 1'b0, 32'h700, 32'h5000);
    cyc = 0;
    while (!(bus_req && bus_we) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    chk("t8_req_now",   bus_req, 0);
    chk("t8_state_now", state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiesce();
    repeat (5) @(negedge clk);
    chk("t8_no_resume", n_req, 0);

    // Random traffic.
    err_pct = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 100 == 0) ack_pct = $urandom_range(40, 100);
      start    = ($urandom_range(0, 99) < 8);
      abort    = ($urandom_range(0, 99) < 2);
      w_count  = 15'($urandom_range(0, 5));
      io_mem   = $urandom_range(0, 1) == 1;
      io_addr  = ($urandom & 32'hFFFF_FFFC) |
                 (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      mem_addr = ($urandom & 32'hFFFF_FFFC) |
                 (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    err_pct = 0;
    ack_pct = 100;
    wait_idle("rand_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
